// File: rtl/audio_ctrl_pkg.sv
// rtl/audio_ctrl_pkg.sv - shared encodings and widths for the audio path sequencer
package audio_ctrl_pkg;
   localparam int GAIN_W     = 9;
   localparam int GAIN_UNITY = 256;
   localparam int PCM_W      = 16;

   typedef enum logic [2:0] {
      ST_OFF       = 3'd0,
      ST_SETTLE    = 3'd1,
      ST_WAKE      = 3'd2,
      ST_RAMP_UP   = 3'd3,
      ST_RUN       = 3'd4,
      ST_RAMP_DOWN = 3'd5,
      ST_MUTED     = 3'd6
   } state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction
endpackage

// File: rtl/audio_path_sequencer_if.sv
// rtl/audio_path_sequencer_if.sv - PCM sample stream from the CIC and gain-scaled stream to I2S
interface audio_path_sequencer_if;
   import audio_ctrl_pkg::*;

   logic signed [PCM_W-1:0] pcm_in;
   logic                    pcm_in_valid;
   logic signed [PCM_W-1:0] pcm_out;
   logic                    pcm_out_valid;

   modport master (output pcm_in, output pcm_in_valid, input pcm_out, input pcm_out_valid);
   modport slave  (input pcm_in, input pcm_in_valid, output pcm_out, output pcm_out_valid);
endinterface

// File: rtl/pcm_gain_stage.sv
// rtl/pcm_gain_stage.sv - registered signed gain multiply, floor shift and saturation
module pcm_gain_stage
   import audio_ctrl_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [PCM_W-1:0] pcm_in,
   input  logic                    pcm_in_valid,
   input  logic [GAIN_W-1:0]       gain,
   output logic signed [PCM_W-1:0] pcm_out,
   output logic                    pcm_out_valid
);
   localparam int PROD_W = PCM_W + GAIN_W + 1;
   localparam int SHIFT  = $clog2(GAIN_UNITY);
   localparam logic signed [PROD_W-1:0] POS_MAX = PROD_W'((2 ** (PCM_W - 1)) - 1);
   localparam logic signed [PROD_W-1:0] NEG_MIN = PROD_W'(-(2 ** (PCM_W - 1)));

   logic signed [PROD_W-1:0] pcm_ext;
   logic signed [PROD_W-1:0] gain_ext;
   logic signed [PROD_W-1:0] product;
   logic signed [PROD_W-1:0] scaled;
   logic signed [PCM_W-1:0]  sat;

   assign pcm_ext  = {{(PROD_W - PCM_W){pcm_in[PCM_W-1]}}, pcm_in};
   assign gain_ext = {{(PROD_W - GAIN_W){1'b0}}, gain};
   assign product  = pcm_ext * gain_ext;
   assign scaled   = product >>> SHIFT;

   // Only gains above unity can overflow; kept as a guard.
   always_comb begin
      sat = scaled[PCM_W-1:0];
      if (scaled > POS_MAX)
         sat = POS_MAX[PCM_W-1:0];
      else if (scaled < NEG_MIN)
         sat = NEG_MIN[PCM_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pcm_out       <= '0;
         pcm_out_valid <= 1'b0;
      end else begin
         pcm_out_valid <= pcm_in_valid;
         if (pcm_in_valid)
            pcm_out <= sat;
      end
   end
endmodule

// File: rtl/audio_path_sequencer.sv
// rtl/audio_path_sequencer.sv - power-up sequencing, gain ramps and howl guard ahead of the I2S sample register
module audio_path_sequencer
   import audio_ctrl_pkg::*;
#(
   parameter int SETTLE_SAMPLES = 4096,
   parameter int WAKE_CYCLES    = 2500000,
   parameter int TARGET_GAIN    = 16,
   parameter int RAMP_DIV       = 16,
   parameter int CLIP_THRESH    = 30000,
   parameter int CLIP_COUNT     = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   audio_path_sequencer_if.slave  bus,
   input  logic                   mute_req,
   output logic                   amp_sd,
   output logic [2:0]             state,
   output logic                   clip_flag,
   output logic [GAIN_W-1:0]      gain
);
   localparam int CNT_W  = $clog2(max3(SETTLE_SAMPLES, WAKE_CYCLES, RAMP_DIV) + 1);
   localparam int CLIP_W = $clog2(CLIP_COUNT + 1);
   localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_SAMPLES - 1);
   localparam logic [CNT_W-1:0]  WAKE_LAST   = CNT_W'(WAKE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  RAMP_LAST   = CNT_W'(RAMP_DIV - 1);
   localparam logic [CLIP_W-1:0] CLIP_LAST   = CLIP_W'(CLIP_COUNT - 1);

   state_t              state_q, state_d;
   logic [GAIN_W-1:0]   gain_q, gain_d, limit_q, limit_d, new_limit;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CLIP_W-1:0]   clip_run_q, clip_run_d;
   logic                clip_flag_q, clip_flag_d;
   logic                trig, guard_on, clip_hit, valid;
   logic signed [PCM_W:0] pcm_wide;
   logic [PCM_W:0]      mag;

   assign valid     = bus.pcm_in_valid;
   assign pcm_wide  = {bus.pcm_in[PCM_W-1], bus.pcm_in};
   assign mag       = pcm_wide[PCM_W] ? -pcm_wide : pcm_wide;
   assign clip_hit  = (mag >= (PCM_W + 1)'(CLIP_THRESH));
   assign guard_on  = (state_q == ST_RAMP_UP) || (state_q == ST_RUN);
   assign new_limit = ((limit_q >> 1) == '0) ? GAIN_W'(1) : (limit_q >> 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_OFF;
         gain_q      <= '0;
         limit_q     <= GAIN_W'(TARGET_GAIN);
         cnt_q       <= '0;
         clip_run_q  <= '0;
         clip_flag_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         gain_q      <= gain_d;
         limit_q     <= limit_d;
         cnt_q       <= cnt_d;
         clip_run_q  <= clip_run_d;
         clip_flag_q <= clip_flag_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      gain_d      = gain_q;
      limit_d     = limit_q;
      cnt_d       = cnt_q;
      clip_run_d  = clip_run_q;
      clip_flag_d = clip_flag_q;
      trig        = 1'b0;

      case (state_q)
         ST_OFF: state_d = ST_SETTLE;
         ST_SETTLE: begin
            if (valid) begin
               if (cnt_q == SETTLE_LAST) state_d = ST_WAKE;
               else                      cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         ST_WAKE: begin
            if (cnt_q == WAKE_LAST) state_d = mute_req ? ST_MUTED : ST_RAMP_UP;
            else                    cnt_d   = cnt_q + CNT_W'(1);
         end
         ST_RAMP_UP: begin
            if (mute_req)
               state_d = ST_RAMP_DOWN;
            else if (gain_q >= limit_q)
               state_d = ST_RUN;
            else if (valid) begin
               if (cnt_q == RAMP_LAST) begin
                  cnt_d  = '0;
                  gain_d = gain_q + GAIN_W'(1);
                  if (gain_d >= limit_q) state_d = ST_RUN;
               end else
                  cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RUN: begin
            gain_d = limit_q;
            if (mute_req) state_d = ST_RAMP_DOWN;
         end
         ST_RAMP_DOWN: begin
            if (!mute_req)
               state_d = ST_RAMP_UP;
            else if (gain_q == '0)
               state_d = ST_MUTED;
            else if (valid) begin
               if (cnt_q == RAMP_LAST) begin
                  cnt_d  = '0;
                  gain_d = gain_q - GAIN_W'(1);
                  if (gain_d == '0) state_d = ST_MUTED;
               end else
                  cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_MUTED: begin
            gain_d = '0;
            if (!mute_req) state_d = ST_RAMP_UP;
         end
         default: state_d = ST_OFF;
      endcase

      // Howl guard: a run of near-full-scale samples permanently halves the limit.
      if (!guard_on)
         clip_run_d = '0;
      else if (valid) begin
         if (!clip_hit)                   clip_run_d = '0;
         else if (clip_run_q == CLIP_LAST) trig       = 1'b1;
         else                             clip_run_d = clip_run_q + CLIP_W'(1);
      end

      if (trig) begin
         limit_d     = new_limit;
         clip_flag_d = 1'b1;
         clip_run_d  = '0;
         if (gain_d >= new_limit) begin
            gain_d = new_limit;
            if (state_d == ST_RAMP_UP) state_d = ST_RUN;
         end
      end

      if (state_d != state_q) cnt_d = '0;
   end

   pcm_gain_stage u_gain (
      .clk           (clk),
      .rst           (rst),
      .pcm_in        (bus.pcm_in),
      .pcm_in_valid  (bus.pcm_in_valid),
      .gain          (gain_q),
      .pcm_out       (bus.pcm_out),
      .pcm_out_valid (bus.pcm_out_valid)
   );

   assign amp_sd    = !((state_q == ST_OFF) || (state_q == ST_SETTLE));
   assign state     = state_q;
   assign clip_flag = clip_flag_q;
   assign gain      = gain_q;
endmodule
